shift_queue_array: RTL and testbench
====================================

Name: shift_queue_array

Overview:
- Parametrised successor to the per-entry multi-input storage register: a complete depth-N shifting queue of {ptr, chan} entries, with occupancy tracking and the shift control built in.
- Supports tail append, insert-at-index, remove-at-index and head dequeue, each completing in one cycle.
- Sits between the op decoder and the channel arbiter.
- Entry 0 is always the head; occupied entries are always contiguous from index 0.

Parameters:
- p_ptrwidth, 5, width of the pointer field (upper bits of an entry)
- p_chanwidth, 32, width of the channel payload (lower bits of an entry)
- p_depth, 8, number of entries (>=2)
- p_idxwidth, $clog2(p_depth), width of index ports
- p_bitwidth, p_ptrwidth+p_chanwidth, entry width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op_val  in  1  op request valid
- op_rdy  out  1  op accepted when op_val&&op_rdy
- op_type  in  2  00 APPEND, 01 INSERT, 10 REMOVE, 11 reserved (treated as no-op, flags op_err)
- op_idx  in  p_idxwidth  target index for INSERT/REMOVE
- op_data  in  p_bitwidth  entry written by APPEND/INSERT
- op_err  out  1  registered, one-cycle pulse after an accepted op that was ignored
- deq_val  in  1  consumer takes the head
- deq_rdy  out  1  head valid
- deq_data  out  p_bitwidth  entry 0, combinational from storage
- count  out  p_idxwidth+1  number of occupied entries
- full  out  1  count==p_depth
- empty  out  1  count==0
- occ  out  p_depth  occ[i]=(i<count)

Behaviour:
- Reset: all entries 0, count=0, op_err=0.
- Reset outputs: empty=1, full=0, occ=0, deq_rdy=0, deq_data=0.
- Reset has priority over any same-cycle op or deq; an in-flight op is discarded.
- deq_rdy = !empty. It must not depend on op_val.
- deq fire: entries 1..count-1 shift forward by one, entry count-1 becomes stale, count decrements.
- op_rdy:
  - APPEND: !full || deq fire.
  - INSERT: !full && !deq_val.
  - REMOVE: !deq_val.
  - Reserved type: 1.
- op_rdy is combinational from op_type, full and deq_val. There is no path from op_val to op_rdy.
- APPEND alone: entry[count] <= op_data; count+1.
- APPEND with deq fire: shift forward, then entry[count-1] <= op_data; count unchanged. This is legal when full.
- INSERT, idx <= count: entries idx..count-1 shift reverse (i <= i-1), entry[idx] <= op_data, count+1.
- INSERT, idx > count: clamped to count, i.e. behaves as APPEND; no error.
- REMOVE, idx < count: entries idx+1..count-1 shift forward, count-1.
- REMOVE, idx >= count (includes empty): no state change, op_err=1 next cycle.
- Unoccupied entries hold their previous value. Only occ/count define validity.
- All state updates occur at posedge clk. Outputs reflect a fire on the next cycle (latency 1); deq_data is combinational from the updated entry 0.
- count never exceeds p_depth and never underflows. Attempts that would do so are blocked by op_rdy/deq_rdy.

Optional Feature:
- Macro: SHIFT_QUEUE_SEARCH_EN.
- Defined: adds ports search_ptr (in, p_ptrwidth), search_hit (out, 1) and search_idx (out, p_idxwidth).
  - search_hit is combinational and set if any occupied entry's ptr field equals search_ptr.
  - search_idx is the lowest matching index, or 0 when there is no hit.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan (p_depth=4, p_ptrwidth=5, p_chanwidth=32):
- Reset, then APPEND 0x01/0xA, 0x02/0xB, 0x03/0xC, 0x04/0xD -> count=4, full=1, occ=4'b1111, deq_data={5'h01,32'hA}, op_rdy=0 for INSERT.
- With queue full, deq_val=1 and APPEND {5'h05,32'hE} in the same cycle -> count=4, entries B,C,D,E, deq_data ptr=0x02.
- Queue A,B: INSERT idx=1 data X -> order A,X,B, count=3. Then INSERT idx=3 data Y (clamped append) -> A,X,B,Y, op_err=0.
- Queue A,X,B,Y: REMOVE idx=1 -> A,B,Y, count=3. Then REMOVE idx=3 -> unchanged, op_err=1 for exactly one cycle.
- deq_val=1 with INSERT pending -> op_rdy=0 for that cycle. Head dequeued, INSERT accepted the next cycle after deq_val drops.
- Assert rst mid-stream with op_val=1 and deq_val=1 -> next cycle count=0, empty=1, deq_data=0. With SHIFT_QUEUE_SEARCH_EN, searching ptr 0x02 on A,B,B -> search_hit=1, search_idx=1.

Source files
------------

// File: rtl/shift_queue_array.sv
// shift_queue_array: depth-N shifting queue of {ptr, chan} entries.
// It sits between the op decoder and the channel arbiter.
// Entry 0 is always the head. Occupied entries are contiguous from index 0.
// Ops are APPEND, INSERT-at-index and REMOVE-at-index, plus head dequeue.
// Each op completes in a single cycle.
// Optional macro SHIFT_QUEUE_SEARCH_EN adds a combinational ptr-field
// search port (search_ptr / search_hit / search_idx).
//
// Handshake semantics:
//   - An op fires on a cycle where op_val && op_rdy are both high.
//   - A dequeue fires on a cycle where deq_val && deq_rdy are both high.
//   - op_rdy is a function of op_type, full, empty and deq_val only; it
//     never looks at op_val.
//   - deq_rdy is a function of occupancy only.
//   - All effects appear on the cycle after the fire.
module shift_queue_array #(
  parameter int p_ptrwidth  = 5,
  parameter int p_chanwidth = 32,
  parameter int p_depth     = 8,
  parameter int p_idxwidth  = $clog2(p_depth),
  parameter int p_bitwidth  = p_ptrwidth + p_chanwidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_val,
  output logic                  op_rdy,
  input  logic [1:0]            op_type,
  input  logic [p_idxwidth-1:0] op_idx,
  input  logic [p_bitwidth-1:0] op_data,
  output logic                  op_err,
  input  logic                  deq_val,
  output logic                  deq_rdy,
  output logic [p_bitwidth-1:0] deq_data,
  output logic [p_idxwidth:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [p_depth-1:0]    occ
`ifdef SHIFT_QUEUE_SEARCH_EN
  ,
  input  logic [p_ptrwidth-1:0] search_ptr,
  output logic                  search_hit,
  output logic [p_idxwidth-1:0] search_idx
`endif
);

  typedef logic [p_idxwidth:0]   cnt_t;
  typedef logic [p_idxwidth-1:0] idx_t;
  typedef logic [p_bitwidth-1:0] entry_t;

  localparam logic [1:0] OP_APPEND = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_REMOVE = 2'b10;
  localparam cnt_t       c_depth   = cnt_t'(p_depth);
  localparam cnt_t       c_one     = cnt_t'(1);

  // Storage and occupancy
  entry_t r_entry [p_depth];
  cnt_t   r_count;
  logic   r_op_err;

  // Neighbour views used by the shift muxes.
  // w_fwd[i] is entry i+1 (a forward shift toward the head).
  // w_rev[i] is entry i-1 (a reverse shift, used to open a gap for insert).
  entry_t w_fwd [p_depth];
  entry_t w_rev [p_depth];

  entry_t w_entry_nxt [p_depth];
  cnt_t   w_count_nxt;
  logic   w_err_nxt;

  logic   w_full;
  logic   w_empty;
  logic   w_deq_fire;
  logic   w_op_fire;
  logic   w_append_fire;
  logic   w_insert_fire;
  logic   w_remove_fire;
  logic   w_remove_ok;
  logic   w_reserved_fire;
  cnt_t   w_op_idx;
  cnt_t   w_ins_idx;
  cnt_t   w_last;

  for (genvar g = 0; g < p_depth; g++) begin : g_nbr
    if (g == p_depth - 1) begin : g_fwd_end
      assign w_fwd[g] = r_entry[g];
    end else begin : g_fwd_mid
      assign w_fwd[g] = r_entry[g+1];
    end
    if (g == 0) begin : g_rev_end
      assign w_rev[g] = r_entry[g];
    end else begin : g_rev_mid
      assign w_rev[g] = r_entry[g-1];
    end
  end

  assign w_full     = (r_count == c_depth);
  assign w_empty    = (r_count == '0);
  assign w_deq_fire = deq_val && !w_empty;

  // Handshake readiness: depends on the op kind, occupancy and deq_val.
  always_comb begin
    op_rdy = 1'b1;
    case (op_type)
      OP_APPEND: op_rdy = !w_full || w_deq_fire;
      OP_INSERT: op_rdy = !w_full && !deq_val;
      OP_REMOVE: op_rdy = !deq_val;
      default:   op_rdy = 1'b1;
    endcase
  end

  assign w_op_fire       = op_val && op_rdy;
  assign w_append_fire   = w_op_fire && (op_type == OP_APPEND);
  assign w_insert_fire   = w_op_fire && (op_type == OP_INSERT);
  assign w_remove_fire   = w_op_fire && (op_type == OP_REMOVE);
  assign w_reserved_fire = w_op_fire && (op_type == 2'b11);
  assign w_op_idx        = {1'b0, op_idx};
  assign w_remove_ok     = w_remove_fire && (w_op_idx < r_count);

  // An insert index beyond the tail is clamped to the tail (plain append).
  assign w_ins_idx = (w_op_idx > r_count) ? r_count : w_op_idx;

  // Index of the last occupied slot.
  // It is only consumed when the queue is non-empty.
  assign w_last = r_count - c_one;

  // Next-entry muxes: shift forward, shift reverse, write new data, or hold.
  always_comb begin
    for (int i = 0; i < p_depth; i++) begin
      w_entry_nxt[i] = r_entry[i];
      if (w_deq_fire) begin
        if (cnt_t'(i) < w_last) begin
          w_entry_nxt[i] = w_fwd[i];
        end
        if (w_append_fire && (cnt_t'(i) == w_last)) begin
          w_entry_nxt[i] = op_data;
        end
      end else if (w_append_fire) begin
        if (cnt_t'(i) == r_count) begin
          w_entry_nxt[i] = op_data;
        end
      end else if (w_insert_fire) begin
        if (cnt_t'(i) == w_ins_idx) begin
          w_entry_nxt[i] = op_data;
        end else if ((cnt_t'(i) > w_ins_idx) && (cnt_t'(i) <= r_count)) begin
          w_entry_nxt[i] = w_rev[i];
        end
      end else if (w_remove_ok) begin
        if ((cnt_t'(i) >= w_op_idx) && (cnt_t'(i) < w_last)) begin
          w_entry_nxt[i] = w_fwd[i];
        end
      end
    end
  end

  // Occupancy count update and the ignored-op error flag.
  always_comb begin
    w_count_nxt = r_count;
    w_err_nxt   = w_reserved_fire || (w_remove_fire && !w_remove_ok);
    if (w_deq_fire) begin
      if (!w_append_fire) begin
        w_count_nxt = r_count - c_one;
      end
    end else if (w_append_fire || w_insert_fire) begin
      w_count_nxt = r_count + c_one;
    end else if (w_remove_ok) begin
      w_count_nxt = r_count - c_one;
    end
  end

  // Entry storage register; reset clears every slot so deq_data reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < p_depth; i++) begin
        r_entry[i] <= '0;
      end
    end else begin
      for (int i = 0; i < p_depth; i++) begin
        r_entry[i] <= w_entry_nxt[i];
      end
    end
  end

  // Count and error register.
  // Reset wins over any op or dequeue in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_op_err <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_op_err <= w_err_nxt;
    end
  end

  // Occupancy vector: slot i is valid when it lies below the count.
  always_comb begin
    occ = '0;
    for (int i = 0; i < p_depth; i++) begin
      occ[i] = (cnt_t'(i) < r_count);
    end
  end

  assign count    = r_count;
  assign full     = w_full;
  assign empty    = w_empty;
  assign deq_rdy  = !w_empty;
  assign deq_data = r_entry[0];
  assign op_err   = r_op_err;

`ifdef SHIFT_QUEUE_SEARCH_EN
  // Ptr search over occupied slots.
  // The loop scans from the top slot down to slot 0, so the lowest
  // matching index is the one that remains.
  always_comb begin
    search_hit = 1'b0;
    search_idx = '0;
    for (int i = p_depth - 1; i >= 0; i--) begin
      if (occ[i] && (r_entry[i][p_bitwidth-1 -: p_ptrwidth] == search_ptr)) begin
        search_hit = 1'b1;
        search_idx = idx_t'(i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_shift_queue_array.sv
// Bench for shift_queue_array (depth 4, ptr 5, chan 32).
// It uses a queue-based reference model and a per-cycle compare process,
// with directed literal checks.
// Define SHIFT_QUEUE_SEARCH_EN to also exercise the search port.
module tb_shift_queue_array;

  localparam int DEPTH = 4;
  localparam int PW    = 5;
  localparam int CW    = 32;
  localparam int IW    = 2;
  localparam int BW    = PW + CW;

  // Clock / reset and DUT wiring
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_val = 1'b0;
  logic          op_rdy;
  logic [1:0]    op_type = 2'b00;
  logic [IW-1:0] op_idx = '0;
  logic [BW-1:0] op_data = '0;
  logic          op_err;
  logic          deq_val = 1'b0;
  logic          deq_rdy;
  logic [BW-1:0] deq_data;
  logic [IW:0]   count;
  logic          full;
  logic          empty;
  logic [DEPTH-1:0] occ;
`ifdef SHIFT_QUEUE_SEARCH_EN
  logic [PW-1:0] search_ptr = '0;
  logic          search_hit;
  logic [IW-1:0] search_idx;
`endif

  always #5 clk = ~clk;

  shift_queue_array #(
    .p_ptrwidth (PW),
    .p_chanwidth(CW),
    .p_depth    (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .op_val  (op_val),
    .op_rdy  (op_rdy),
    .op_type (op_type),
    .op_idx  (op_idx),
    .op_data (op_data),
    .op_err  (op_err),
    .deq_val (deq_val),
    .deq_rdy (deq_rdy),
    .deq_data(deq_data),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .occ     (occ)
`ifdef SHIFT_QUEUE_SEARCH_EN
    ,
    .search_ptr(search_ptr),
    .search_hit(search_hit),
    .search_idx(search_idx)
`endif
  );

  // Scoreboard counters
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [BW-1:0] ent(input logic [PW-1:0] p, input logic [CW-1:0] c);
    return {p, c};
  endfunction

  // Reference model: the queue contents as a plain SV queue, head at index 0
  logic [BW-1:0] exp_q[$];
  logic          m_err = 1'b0;
  bit            chk_en = 1'b0;

  function automatic logic m_op_rdy();
    int n;
    n = exp_q.size();
    case (op_type)
      2'b00:   return (n < DEPTH) || (deq_val && n > 0);
      2'b01:   return (n < DEPTH) && !deq_val;
      2'b10:   return !deq_val;
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic deq_fire;
    logic op_fire;
    int   idx;
    if (rst) begin
      exp_q.delete();
      m_err = 1'b0;
    end else begin
      deq_fire = deq_val && (exp_q.size() > 0);
      op_fire  = op_val && m_op_rdy();
      m_err    = 1'b0;
      if (deq_fire) void'(exp_q.pop_front());
      if (op_fire) begin
        case (op_type)
          2'b00: exp_q.push_back(op_data);
          2'b01: begin
            idx = int'(op_idx);
            if (idx > exp_q.size()) idx = exp_q.size();
            exp_q.insert(idx, op_data);
          end
          2'b10: begin
            idx = int'(op_idx);
            if (idx < exp_q.size()) exp_q.delete(idx);
            else m_err = 1'b1;
          end
          default: m_err = 1'b1;
        endcase
      end
    end
  end

  // Compare process: all outputs against the model every cycle, on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [DEPTH-1:0] eo;
      eo = DEPTH'((1 << exp_q.size()) - 1);
      check("cmp_count", 64'(count), 64'(exp_q.size()));
      check("cmp_full", 64'(full), 64'(exp_q.size() == DEPTH));
      check("cmp_empty", 64'(empty), 64'(exp_q.size() == 0));
      check("cmp_occ", 64'(occ), 64'(eo));
      check("cmp_deq_rdy", 64'(deq_rdy), 64'(exp_q.size() > 0));
      check("cmp_op_rdy", 64'(op_rdy), 64'(m_op_rdy()));
      check("cmp_op_err", 64'(op_err), 64'(m_err));
      if (exp_q.size() > 0) check("cmp_deq_data", 64'(deq_data), 64'(exp_q[0]));
`ifdef SHIFT_QUEUE_SEARCH_EN
      begin
        logic          h;
        logic [IW-1:0] si;
        h  = 1'b0;
        si = '0;
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
          if (exp_q[k][BW-1 -: PW] == search_ptr) begin
            h  = 1'b1;
            si = IW'(k);
          end
        end
        check("cmp_search_hit", 64'(search_hit), 64'(h));
        check("cmp_search_idx", 64'(search_idx), 64'(si));
      end
`endif
    end
  end

  // Driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] t, input logic [IW-1:0] i, input logic [BW-1:0] d);
    op_val  = 1'b1;
    op_type = t;
    op_idx  = i;
    op_data = d;
    cycle();
    op_val  = 1'b0;
  endtask

  logic [BW-1:0] ea, eb, ec, ed, ee, ex, ey, ez, ew;

  initial begin
    ea = ent(5'h01, 32'hA);
    eb = ent(5'h02, 32'hB);
    ec = ent(5'h03, 32'hC);
    ed = ent(5'h04, 32'hD);
    ee = ent(5'h05, 32'hE);
    ex = ent(5'h06, 32'h11);
    ey = ent(5'h07, 32'h22);
    ez = ent(5'h08, 32'h33);
    ew = ent(5'h09, 32'h44);

    // Reset
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_occ", 64'(occ), 64'd0);
    check("rst_deq_rdy", 64'(deq_rdy), 64'd0);
    check("rst_deq_data", 64'(deq_data), 64'd0);
    check("rst_op_err", 64'(op_err), 64'd0);

    // Fill to full
    do_op(2'b00, '0, ea);
    do_op(2'b00, '0, eb);
    do_op(2'b00, '0, ec);
    do_op(2'b00, '0, ed);
    check("fill_count", 64'(count), 64'd4);
    check("fill_full", 64'(full), 64'd1);
    check("fill_occ", 64'(occ), 64'hF);
    check("fill_head", 64'(deq_data), 64'(ea));
    op_type = 2'b01;
    #1;
    check("full_insert_rdy", 64'(op_rdy), 64'd0);
    op_type = 2'b00;
    #1;
    check("full_append_rdy", 64'(op_rdy), 64'd0);

    // Append while dequeuing on a full queue
    deq_val = 1'b1;
    op_val  = 1'b1;
    op_type = 2'b00;
    op_data = ee;
    #1;
    check("full_deq_append_rdy", 64'(op_rdy), 64'd1);
    cycle();
    op_val  = 1'b0;
    deq_val = 1'b0;
    check("deqapp_count", 64'(count), 64'd4);
    check("deqapp_head_ptr", 64'(deq_data[BW-1 -: PW]), 64'h02);

    // Drain B, C, D, E
    deq_val = 1'b1;
    repeat (4) cycle();
    deq_val = 1'b0;
    check("drain_empty", 64'(empty), 64'd1);

    // Insert: A,B -> A,X,B -> A,X,B,Y
    do_op(2'b00, '0, ea);
    do_op(2'b00, '0, eb);
    do_op(2'b01, 2'd1, ex);
    check("ins1_count", 64'(count), 64'd3);
    do_op(2'b01, 2'd3, ey);
    check("ins2_count", 64'(count), 64'd4);
    check("ins2_op_err", 64'(op_err), 64'd0);
    check("ins2_head", 64'(deq_data), 64'(ea));

    // Remove: A,X,B,Y -> A,B,Y; then out-of-range remove
    do_op(2'b10, 2'd1, '0);
    check("rm1_count", 64'(count), 64'd3);
    do_op(2'b10, 2'd3, '0);
    check("rm_oob_count", 64'(count), 64'd3);
    check("rm_oob_err", 64'(op_err), 64'd1);
    cycle();
    check("rm_oob_err_pulse", 64'(op_err), 64'd0);
    deq_val = 1'b1;
    cycle();
    deq_val = 1'b0;
    check("rm_next_head", 64'(deq_data), 64'(eb));

    // INSERT stalled by deq_val, accepted once deq_val drops (queue B,Y)
    deq_val = 1'b1;
    op_val  = 1'b1;
    op_type = 2'b01;
    op_idx  = 2'd0;
    op_data = ez;
    #1;
    check("ins_stall_rdy", 64'(op_rdy), 64'd0);
    cycle();
    deq_val = 1'b0;
    #1;
    check("ins_resume_rdy", 64'(op_rdy), 64'd1);
    check("ins_stall_head", 64'(deq_data), 64'(ey));
    cycle();
    op_val = 1'b0;
    check("ins_late_head", 64'(deq_data), 64'(ez));
    check("ins_late_count", 64'(count), 64'd2);

    // Clamped insert: idx 3 with count 2 -> Z,Y,W
    do_op(2'b01, 2'd3, ew);
    check("clamp_count", 64'(count), 64'd3);
    check("clamp_err", 64'(op_err), 64'd0);

    // Reserved op type
    do_op(2'b11, '0, ea);
    check("rsv_err", 64'(op_err), 64'd1);
    check("rsv_count", 64'(count), 64'd3);

    // Reset mid-stream with op and deq active
    rst     = 1'b1;
    op_val  = 1'b1;
    op_type = 2'b00;
    op_data = ee;
    deq_val = 1'b1;
    cycle();
    rst     = 1'b0;
    op_val  = 1'b0;
    deq_val = 1'b0;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_empty", 64'(empty), 64'd1);
    check("mid_rst_deq_data", 64'(deq_data), 64'd0);

    // Remove on empty flags an error; append with deq_val on empty appends
    do_op(2'b10, 2'd0, '0);
    check("rm_empty_err", 64'(op_err), 64'd1);
    deq_val = 1'b1;
    do_op(2'b00, '0, ea);
    deq_val = 1'b0;
    check("app_empty_deq_count", 64'(count), 64'd1);
    check("app_empty_deq_head", 64'(deq_data), 64'(ea));

    // A,B,B for search
    do_op(2'b00, '0, eb);
    do_op(2'b00, '0, eb);
`ifdef SHIFT_QUEUE_SEARCH_EN
    search_ptr = 5'h02;
    #1;
    check("search_hit", 64'(search_hit), 64'd1);
    check("search_idx", 64'(search_idx), 64'd1);
    search_ptr = 5'h1F;
    #1;
    check("search_miss_hit", 64'(search_hit), 64'd0);
    check("search_miss_idx", 64'(search_idx), 64'd0);
`endif
    check("abb_count", 64'(count), 64'd3);

    repeat (3) cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
